// File: rtl/dbg_loader.sv
// Debug-bus program loader: holds the CPU in reset, streams words into memory
// over the debug bus (optionally verifying each one by readback), then releases the CPU.
module dbg_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int          HOLD_CYCLES = 4,
    parameter int          VERIFY      = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    input  logic [31:0] dbg_di,
    output logic        cpu_n_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_r;
    state_t      state_next;
    logic [7:0]  hold_cnt_r;
    logic [15:0] count_r;
    logic [31:0] addr_r;

    logic        in_ready_r;
    logic        dbg_mem_op_r;
    logic [3:0]  dbg_wren_r;
    logic [31:0] dbg_adr_r;
    logic [31:0] dbg_do_r;
    logic        cpu_n_reset_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;

    logic        start_take_s;
    logic        accept_s;
    logic        advance_s;
    logic        fail_s;
    logic        hold_last_s;
    logic        last_word_s;

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_next   = state_r;
        start_take_s = 1'b0;
        accept_s     = 1'b0;
        advance_s    = 1'b0;
        fail_s       = 1'b0;
        hold_last_s  = (hold_cnt_r == HOLD_LAST);
        last_word_s  = (count_r == 16'd1);
        case (state_r)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    start_take_s = 1'b1;
                    if (word_count != 16'd0) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end else begin
                    state_next = state_r;
                end
            end
            ST_FETCH: begin
                if (in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_WRITE: begin
                if (!hold_last_s) begin
                    state_next = ST_WRITE;
                end else if (VERIFY != 0) begin
                    state_next = ST_READ;
                end else begin
                    advance_s  = 1'b1;
                    state_next = last_word_s ? ST_RELEASE : ST_FETCH;
                end
            end
            ST_READ: begin
                if (!hold_last_s) begin
                    state_next = ST_READ;
                end else if (dbg_di != dbg_do_r) begin
                    fail_s     = 1'b1;
                    state_next = ST_FAIL;
                end else begin
                    advance_s  = 1'b1;
                    state_next = last_word_s ? ST_RELEASE : ST_FETCH;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, hold-cycle counter and session address/count.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 8'd0;
            count_r    <= 16'd0;
            addr_r     <= 32'd0;
        end else begin
            state_r <= state_next;
            if (state_next != state_r) begin
                hold_cnt_r <= 8'd0;
            end else if (state_r == ST_WRITE || state_r == ST_READ) begin
                hold_cnt_r <= hold_cnt_r + 8'd1;
            end else begin
                hold_cnt_r <= 8'd0;
            end
            if (start_take_s) begin
                count_r <= word_count;
                addr_r  <= BASE_ADDR;
            end else if (advance_s) begin
                count_r <= count_r - 16'd1;
                addr_r  <= addr_r + 32'd4;
            end else begin
                count_r <= count_r;
                addr_r  <= addr_r;
            end
        end
    end

    // Bus and handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            in_ready_r   <= 1'b0;
            dbg_mem_op_r <= 1'b0;
            dbg_wren_r   <= 4'h0;
            dbg_adr_r    <= 32'd0;
            dbg_do_r     <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            in_ready_r   <= (state_next == ST_FETCH);
            dbg_mem_op_r <= (state_next == ST_WRITE) || (state_next == ST_READ);
            dbg_wren_r   <= (state_next == ST_WRITE) ? 4'hF : 4'h0;
            busy_r       <= (state_next == ST_FETCH) || (state_next == ST_WRITE) ||
                            (state_next == ST_READ)  || (state_next == ST_RELEASE);
            if (accept_s) begin
                dbg_do_r  <= in_data;
                dbg_adr_r <= addr_r;
            end else begin
                dbg_do_r  <= dbg_do_r;
                dbg_adr_r <= dbg_adr_r;
            end
        end
    end

    // Session status: CPU stays in reset from any accepted start until a clean release.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cpu_n_reset_r <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else if (start_take_s) begin
            cpu_n_reset_r <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else if (state_r == ST_RELEASE) begin
            cpu_n_reset_r <= 1'b1;
            done_r        <= 1'b1;
            error_r       <= error_r;
        end else if (fail_s) begin
            cpu_n_reset_r <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b1;
        end else begin
            cpu_n_reset_r <= cpu_n_reset_r;
            done_r        <= done_r;
            error_r       <= error_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign dbg_mem_op  = dbg_mem_op_r;
    assign dbg_wren    = dbg_wren_r;
    assign dbg_adr     = dbg_adr_r;
    assign dbg_do      = dbg_do_r;
    assign cpu_n_reset = cpu_n_reset_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;

endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: two instances (verifying at default base, non-verifying at a
// wrapping base), random word streams, and a queue of expected bus operations per instance.
module tb_dbg_loader;

    localparam int NDUT = 2;
    localparam int HOLD = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
    } op_t;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start      [NDUT];
    logic [15:0] word_count [NDUT];
    logic        in_valid   [NDUT];
    logic [31:0] in_data    [NDUT];
    logic        in_ready   [NDUT];
    logic        dbg_mem_op [NDUT];
    logic [3:0]  dbg_wren   [NDUT];
    logic [31:0] dbg_adr    [NDUT];
    logic [31:0] dbg_do     [NDUT];
    logic        cpu_n_reset[NDUT];
    logic        busy       [NDUT];
    logic        done       [NDUT];
    logic        error      [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    op_t         exp_q       [NDUT][$];
    logic        corrupt_on  [NDUT];
    logic [31:0] corrupt_adr [NDUT];
    logic        ignore_run  [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] base_of(input int idx);
        return (idx == 0) ? 32'h0002_0000 : 32'hFFFF_FFFC;
    endfunction

    function automatic int verify_of(input int idx);
        return (idx == 0) ? 1 : 0;
    endfunction

    function automatic wq_t rand_words(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [31:0] di_g;

        dbg_loader #(
            .BASE_ADDR  ((g == 0) ? 32'h0002_0000 : 32'hFFFF_FFFC),
            .HOLD_CYCLES(HOLD),
            .VERIFY     ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .n_reset    (n_reset),
            .start      (start[g]),
            .word_count (word_count[g]),
            .in_valid   (in_valid[g]),
            .in_data    (in_data[g]),
            .in_ready   (in_ready[g]),
            .dbg_mem_op (dbg_mem_op[g]),
            .dbg_wren   (dbg_wren[g]),
            .dbg_adr    (dbg_adr[g]),
            .dbg_do     (dbg_do[g]),
            .dbg_di     (di_g),
            .cpu_n_reset(cpu_n_reset[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .error      (error[g])
        );

        // Monitor: collapses each bus operation into one record, checks it against the
        // queue head, and acts as the memory (echo, optionally corrupting one address).
        initial begin : monitor
            logic        run_on;
            logic        run_wr;
            int          run_len;
            logic [31:0] run_adr;
            logic [31:0] run_do;
            logic [31:0] mem_m [64];
            op_t         e;
            run_on  = 1'b0;
            run_wr  = 1'b0;
            run_len = 0;
            run_adr = 32'h0;
            run_do  = 32'h0;
            di_g    = 32'h0;
            for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
            forever begin
                @(negedge clk);
                if (run_on && (!dbg_mem_op[g] || ((dbg_wren[g] == 4'hF) != run_wr))) begin
                    run_on = 1'b0;
                    if (!ignore_run[g]) begin
                        checks++;
                        if (exp_q[g].size() == 0) begin
                            errors++;
                            $display("FAIL dut%0d unexpected_op: got wr=%0b adr=%h len=%0d, required no bus op",
                                     g, run_wr, run_adr, run_len);
                        end else begin
                            e = exp_q[g].pop_front();
                            if (e.wr !== run_wr || e.adr !== run_adr ||
                                (run_wr && e.data !== run_do) || run_len != HOLD) begin
                                errors++;
                                $display("FAIL dut%0d bus_op: got wr=%0b adr=%h data=%h len=%0d, required wr=%0b adr=%h data=%h len=%0d",
                                         g, run_wr, run_adr, run_do, run_len, e.wr, e.adr,
                                         run_wr ? e.data : run_do, HOLD);
                            end
                        end
                    end
                end
                if (dbg_mem_op[g]) begin
                    if (!run_on) begin
                        run_on  = 1'b1;
                        run_wr  = (dbg_wren[g] == 4'hF);
                        run_adr = dbg_adr[g];
                        run_do  = dbg_do[g];
                        run_len = 1;
                    end else begin
                        run_len++;
                    end
                    checks++;
                    if (dbg_wren[g] != 4'hF && dbg_wren[g] != 4'h0) begin
                        errors++;
                        $display("FAIL dut%0d wren_value: got %h, required F or 0", g, dbg_wren[g]);
                    end
                    if (run_wr) begin
                        mem_m[dbg_adr[g][7:2]] = dbg_do[g];
                    end else begin
                        di_g = mem_m[dbg_adr[g][7:2]] ^
                               ((corrupt_on[g] && dbg_adr[g] == corrupt_adr[g]) ? 32'h1 : 32'h0);
                    end
                end
            end
        end
    end

    task automatic check(input int idx, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL dut%0d %s: got %h, required %h", idx, name, got, want);
        end
    endtask

    task automatic check_reset_vals(input int idx, input string tag);
        check(idx, {tag, "_cpu_n_reset"}, 32'(cpu_n_reset[idx]), 32'h0);
        check(idx, {tag, "_mem_op"},      32'(dbg_mem_op[idx]),  32'h0);
        check(idx, {tag, "_wren"},        32'(dbg_wren[idx]),    32'h0);
        check(idx, {tag, "_adr"},         dbg_adr[idx],          32'h0);
        check(idx, {tag, "_do"},          dbg_do[idx],           32'h0);
        check(idx, {tag, "_in_ready"},    32'(in_ready[idx]),    32'h0);
        check(idx, {tag, "_busy"},        32'(busy[idx]),        32'h0);
        check(idx, {tag, "_done"},        32'(done[idx]),        32'h0);
        check(idx, {tag, "_error"},       32'(error[idx]),       32'h0);
    endtask

    // One load session: expected bus ops are queued from the word list up front,
    // then words are fed and the final status is checked.
    task automatic run_session(input int idx, input wq_t words, input int corrupt_k,
                               input bit fast, input bit poke);
        int n;
        int fed;
        int t;
        int t0;
        int lat;
        bit fails;
        n     = words.size();
        fails = (corrupt_k >= 0) && (corrupt_k < n) && (verify_of(idx) != 0);
        lat   = 1 + HOLD * (1 + verify_of(idx));
        fed   = fails ? corrupt_k + 1 : n;
        for (int i = 0; i < fed; i++) begin
            exp_q[idx].push_back(op_t'{wr: 1'b1, adr: base_of(idx) + 32'(4 * i), data: words[i]});
            if (verify_of(idx) != 0)
                exp_q[idx].push_back(op_t'{wr: 1'b0, adr: base_of(idx) + 32'(4 * i), data: 32'h0});
        end
        corrupt_on[idx]  = fails;
        corrupt_adr[idx] = base_of(idx) + 32'(4 * corrupt_k);

        @(negedge clk);
        start[idx]      = 1'b1;
        word_count[idx] = 16'(n);
        @(negedge clk);
        start[idx] = 1'b0;
        t0 = cyc;
        check(idx, "start_cpu_n_reset", 32'(cpu_n_reset[idx]), 32'h0);
        check(idx, "start_busy",        32'(busy[idx]),        32'h1);
        if (poke) begin
            start[idx]      = 1'b1;
            word_count[idx] = 16'd7;
            @(negedge clk);
            start[idx] = 1'b0;
        end

        for (int i = 0; i < fed; i++) begin
            if (!fast) begin
                in_valid[idx] = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_valid[idx] = 1'b1;
            in_data[idx]  = words[i];
            t = 0;
            while (!in_ready[idx] && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready[idx]) begin
                checks++;
                errors++;
                $display("FAIL dut%0d in_ready_wait: got timeout at word %0d, required in_ready=1", idx, i);
                break;
            end
            @(negedge clk);
        end
        in_valid[idx] = 1'b0;

        t = 0;
        while (!done[idx] && !error[idx] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(idx, "end_wait_timeout", 32'(t >= 2000), 32'h0);
        if (fast && !fails)
            check(idx, "session_latency", 32'(cyc - t0), 32'(n * lat + 1));
        check(idx, "end_done",        32'(done[idx]),        32'(!fails));
        check(idx, "end_error",       32'(error[idx]),       32'(fails));
        check(idx, "end_cpu_n_reset", 32'(cpu_n_reset[idx]), 32'(!fails));
        check(idx, "end_busy",        32'(busy[idx]),        32'h0);
        @(negedge clk);
        check(idx, "ops_outstanding", 32'(exp_q[idx].size()), 32'h0);
        if (fails) begin
            repeat (6) begin
                @(negedge clk);
                check(idx, "fail_no_fetch", 32'(in_ready[idx]), 32'h0);
            end
        end
        corrupt_on[idx] = 1'b0;
    endtask

    // Stall in FETCH with in_valid low, then pull reset in the middle of the write.
    task automatic stall_reset_test();
        @(negedge clk);
        start[0]      = 1'b1;
        word_count[0] = 16'd2;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) begin
            check(0, "stall_in_ready", 32'(in_ready[0]), 32'h1);
            @(negedge clk);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = $urandom;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        check(0, "mid_write_mem_op", 32'(dbg_mem_op[0]), 32'h1);
        ignore_run[0] = 1'b1;
        n_reset = 1'b0;
        #1;
        check_reset_vals(0, "async_reset");
        exp_q[0].delete();
        @(negedge clk);
        n_reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check(0, "post_reset_mem_op",      32'(dbg_mem_op[0]),  32'h0);
            check(0, "post_reset_cpu_n_reset", 32'(cpu_n_reset[0]), 32'h0);
            check(0, "post_reset_busy",        32'(busy[0]),        32'h0);
        end
        ignore_run[0] = 1'b0;
    endtask

    initial begin
        wq_t empty_q;
        wq_t fixed_q;
        n_reset = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            start[i]       = 1'b0;
            word_count[i]  = 16'd0;
            in_valid[i]    = 1'b0;
            in_data[i]     = 32'h0;
            corrupt_on[i]  = 1'b0;
            corrupt_adr[i] = 32'h0;
            ignore_run[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) check_reset_vals(i, "reset");
        n_reset = 1'b1;
        @(negedge clk);

        run_session(0, rand_words(3), -1, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++)
            run_session(0, rand_words($urandom_range(1, 6)), -1, 1'b0, s == 1);
        run_session(0, empty_q, -1, 1'b1, 1'b0);
        run_session(0, rand_words(3), 1, 1'b0, 1'b0);
        run_session(0, rand_words(2), -1, 1'b1, 1'b0);
        stall_reset_test();

        fixed_q.push_back(32'hFE01_0113);
        fixed_q.push_back(32'h0001_2E23);
        run_session(1, fixed_q, -1, 1'b1, 1'b0);
        run_session(1, rand_words(5), -1, 1'b0, 1'b0);
        run_session(1, empty_q, -1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_loader.md
DBG_LOADER -- requirements
Module: dbg_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h20000, byte address of first word written.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles each debug write/read is held on the bus (legal range 1..255).
REQ-003 SHALL have parameter VERIFY, default 1; 1 enables readback compare after each write, 0 disables it.
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse beginning a load session.
REQ-007 SHALL have port word_count  input  16  number of 32-bit words to load, sampled on start.
REQ-008 SHALL have ports in_valid/in_data[31:0]  input and in_ready  output  word stream carrying program data.
REQ-009 SHALL have ports dbg_mem_op  output  1, dbg_wren  output  4, dbg_adr  output  32, dbg_do  output  32  debug memory bus.
REQ-010 SHALL have port dbg_di  input  32  debug read data, valid in the last hold cycle of a read.
REQ-011 SHALL have port cpu_n_reset  output  1  active-low CPU reset.
REQ-012 SHALL have ports busy, done, error  output  1 each  status.

Function
REQ-013 SHALL implement states IDLE, FETCH, WRITE, READ, RELEASE, FAIL.
REQ-014 IDLE: start with word_count>0 SHALL latch count, set address to BASE_ADDR, clear done/error, go FETCH; word_count==0 SHALL go directly to RELEASE.
REQ-015 FETCH: in_ready SHALL be 1 only in FETCH; a word SHALL be accepted on the cycle in_valid && in_ready, latched into dbg_do, state -> WRITE.
REQ-016 WRITE: dbg_mem_op=1, dbg_wren=4'hF, dbg_adr=current address for exactly HOLD_CYCLES cycles, then READ if VERIFY=1 else advance.
REQ-017 READ: dbg_mem_op=1, dbg_wren=4'h0 for HOLD_CYCLES cycles; dbg_di compared to latched word in the final cycle; mismatch -> FAIL, match -> advance.
REQ-018 Advance: address += 4 (32-bit wrap, no saturation), remaining count -= 1; count reaching 0 -> RELEASE, else FETCH.
REQ-019 RELEASE: one cycle with dbg_mem_op=0, dbg_wren=0; then cpu_n_reset=1, done=1, state IDLE.
REQ-020 FAIL: error=1, cpu_n_reset stays 0, bus idle; only a new start (or reset) leaves FAIL, re-entering as from IDLE.
REQ-021 cpu_n_reset SHALL go 0 on the cycle after start is accepted and remain 0 through WRITE/READ/FETCH; it SHALL stay 1 after a successful session until the next start.
REQ-022 busy SHALL be 1 in FETCH, WRITE, READ, RELEASE; start while busy SHALL be ignored.
REQ-023 Outside WRITE/READ, dbg_mem_op=0 and dbg_wren=0; dbg_adr/dbg_do hold last values.
REQ-024 in_valid stalls in FETCH SHALL hold state indefinitely with no timeout.
REQ-025 Latency per word with in_valid already high: 1 + HOLD_CYCLES (+ HOLD_CYCLES if VERIFY) cycles.

Reset
REQ-026 n_reset low SHALL asynchronously force IDLE, cpu_n_reset=0, dbg_mem_op=0, dbg_wren=0, dbg_adr=0, dbg_do=0, in_ready=0, busy=0, done=0, error=0.
REQ-027 Reset asserted mid-session SHALL abandon the session; no partial write is completed after release of reset.
REQ-028 After reset the CPU SHALL remain in reset until a session completes successfully.

Verification
REQ-029 VERIFY=0, HOLD_CYCLES=4, start, word_count=2, words fe010113, 00012e23 -> writes at 0x20000, 0x20004 each 4 cycles with wren=F, then cpu_n_reset=1, done=1.
REQ-030 VERIFY=1, memory model echoes writes -> each word followed by 4-cycle read with wren=0, done=1, error=0.
REQ-031 VERIFY=1, model corrupts second readback -> FAIL, error=1, cpu_n_reset=0, no third FETCH; subsequent start restarts at BASE_ADDR.
REQ-032 start with word_count=0 -> no bus activity, cpu_n_reset=1 and done=1 two cycles later.
REQ-033 in_valid held low 10 cycles in FETCH, then n_reset pulsed low mid-WRITE -> in_ready=1 throughout stall; after reset all outputs at reset values, cpu_n_reset=0.
REQ-034 BASE_ADDR=32'hFFFFFFFC, word_count=2 -> second write at 0x00000000.
